atualiza_asteroides: RTL and testbench
======================================

ATUALIZA_ASTEROIDES -- requirements
Module: atualiza_asteroides

Interface
REQ-001 SHALL have parameter N, default 4: coordinate width in bits.
REQ-002 SHALL have parameter NUM_AST, default 8: number of asteroid entries, at least 1.
REQ-003 SHALL have parameter STEP, default 1: move distance per update, 1 to 2^N-1.
REQ-004 SHALL use one clock; reset is synchronous and active-high.
REQ-005 SHALL have port clock, input, 1 bit: rising-edge clock.
REQ-006 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-007 SHALL have port iniciar, input, 1 bit: start request, sampled only in IDLE.
REQ-008 SHALL have port modo, input, 1 bit: sampled with iniciar; 0 = move all entries, 1 = spawn one entry.
REQ-009 SHALL have port spawn_idx, input, clog2(NUM_AST) bits: target entry when modo=1.
REQ-010 SHALL have ports random_x and random_y, input, N bits each, and random_opcode, input, 2 bits: random source.
REQ-011 SHALL have port mem_addr, output, clog2(NUM_AST) bits: entry address, max(1, clog2(NUM_AST)) bits when NUM_AST=1.
REQ-012 SHALL have port mem_rdata, input, 2N+2 bits: read data, valid one cycle after mem_addr.
REQ-013 SHALL have ports mem_we, output, 1 bit, and mem_wdata, output, 2N+2 bits: write strobe and data.
REQ-014 SHALL have port ocupado, output, 1 bit: high in every state other than IDLE.
REQ-015 SHALL have port pronto, output, 1 bit: one-cycle completion pulse.

Function
REQ-016 SHALL pack each entry word as {x[N-1:0], y[N-1:0], opcode[1:0]}, with x in the MSBs.
REQ-017 SHALL decode opcode as 00 = y-STEP, 01 = y+STEP, 10 = x-STEP, 11 = x+STEP; the opcode is written back unchanged.
REQ-018 SHALL implement the FSM IDLE, LER, CAPTURA, ESCREVE, FIM.
REQ-019 SHALL move from IDLE to LER when iniciar=1 and modo=0, with index=0, or to ESCREVE when iniciar=1 and modo=1.
REQ-020 SHALL drive mem_addr=index in LER, register the new word computed from mem_rdata in CAPTURA, and assert mem_we=1 for exactly one cycle in ESCREVE at the same address.
REQ-021 SHALL return from ESCREVE to LER with index+1, or go to FIM after index NUM_AST-1 or after a spawn; FIM asserts pronto, then returns to IDLE.
REQ-022 SHALL time modo=0 as: iniciar sampled at edge k, entry i written in cycle k+3+3i, pronto in cycle k+3*NUM_AST+1.
REQ-023 SHALL time modo=1 as: {random_x, random_y, random_opcode} written to spawn_idx in cycle k+1, pronto in k+2, with no other address written.
REQ-024 SHALL ignore iniciar while ocupado=1, with no queuing.
REQ-025 SHALL sample the random inputs in the cycle they are used: CAPTURA for respawn, ESCREVE for spawn.
REQ-026 SHALL hold mem_we=0 and pronto=0 in every state except those named above.

Reset
REQ-027 SHALL on reset enter IDLE with index=0, ocupado=0, pronto=0, mem_we=0, mem_addr=0, mem_wdata=0.
REQ-028 SHALL, on reset asserted mid-operation, produce no write in the following cycle and no pronto; memory keeps entries already written, and the next iniciar restarts from index 0.

Configuration
REQ-029 SHALL, with macro ASTRO_WRAP_EN defined, compute coordinates modulo 2^N, e.g. x=2^N-1 with opcode 11 gives x=STEP-1.
REQ-030 SHALL, without ASTRO_WRAP_EN, replace an entry whose move leaves the range 0..2^N-1 with {random_x, random_y, random_opcode}; in-range moves are unchanged.

Structure
REQ-031 SHALL place the opcode constants OP_CIMA, OP_BAIXO, OP_ESQ, OP_DIR, the FSM state encoding and the entry-word width function in shared package astro_pkg.
REQ-032 SHALL put the next-word computation (move, wrap or respawn, repack) in combinational sub-module calc_pos, the generalised successor of the position mux.

Verification (N=4, NUM_AST=4, STEP=1)
REQ-033 SHALL cover: entry0={5,7,11}, modo=0 -> word {6,7,11} written at addr 0 in cycle k+3, pronto in k+13, one write per address.
REQ-034 SHALL cover: entry1={15,4,11} -> with ASTRO_WRAP_EN {0,4,11}; without it, random={3,9,01} gives {3,9,01} (10'h0E5).
REQ-035 SHALL cover: entry2={8,0,00} -> with ASTRO_WRAP_EN {8,15,00}; without it, respawned from the random inputs.
REQ-036 SHALL cover: modo=1, spawn_idx=2, random={3,9,01} -> a single write of 10'h0E5 to addr 2 in cycle k+1, pronto in k+2.
REQ-037 SHALL cover: reset at cycle k+5 of a sweep -> mem_we=0 and ocupado=0 from k+6, entries 0..1 unchanged after that point, and a new iniciar writes addr 0 first.
REQ-038 SHALL cover: iniciar pulsed at k+4 during a sweep -> ignored, exactly 4 writes and 1 pronto pulse.

Source files
------------

// File: rtl/atualiza_asteroides_pkg.sv
// Shared definitions for the asteroid updater: direction opcodes,
// FSM state encoding and the packed entry-word width.
package astro_pkg;

   localparam logic [1:0] OP_CIMA  = 2'b00;  // y - STEP
   localparam logic [1:0] OP_BAIXO = 2'b01;  // y + STEP
   localparam logic [1:0] OP_ESQ   = 2'b10;  // x - STEP
   localparam logic [1:0] OP_DIR   = 2'b11;  // x + STEP

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      LER     = 3'd1,
      CAPTURA = 3'd2,
      ESCREVE = 3'd3,
      FIM     = 3'd4
   } estado_t;

   // Entry word is {x, y, opcode}.
   function automatic int word_width(input int n);
      return 2 * n + 2;
   endfunction

endpackage

// File: rtl/atualiza_asteroides_calc_pos.sv
// Next-word computation for one asteroid entry: move by STEP, then wrap
// (ASTRO_WRAP_EN defined) or respawn from the random inputs on leaving the field.
module calc_pos
   import astro_pkg::*;
#(
   parameter int N    = 4,
   parameter int STEP = 1,
   localparam int W   = word_width(N)
) (
   input  logic [W-1:0] word_in,
   input  logic [N-1:0] random_x,
   input  logic [N-1:0] random_y,
   input  logic [1:0]   random_opcode,
   output logic [W-1:0] word_out
);

   localparam logic [N:0] STEP_E = (N + 1)'(STEP);

   logic [N:0] x_e, y_e, x_n, y_n;
   logic [1:0] op;

   // One spare MSB per coordinate turns an out-of-range move into a carry/borrow.
   always_comb begin
      op  = word_in[1:0];
      x_e = {1'b0, word_in[W-1 -: N]};
      y_e = {1'b0, word_in[N+1 -: N]};
      x_n = x_e;
      y_n = y_e;
      case (op)
         OP_CIMA:  y_n = y_e - STEP_E;
         OP_BAIXO: y_n = y_e + STEP_E;
         OP_ESQ:   x_n = x_e - STEP_E;
         OP_DIR:   x_n = x_e + STEP_E;
      endcase
`ifdef ASTRO_WRAP_EN
      word_out = {x_n[N-1:0], y_n[N-1:0], op};
`else
      if (x_n[N] | y_n[N])
         word_out = {random_x, random_y, random_opcode};
      else
         word_out = {x_n[N-1:0], y_n[N-1:0], op};
`endif
   end

endmodule

// File: rtl/atualiza_asteroides.sv
// Sweeps (modo=0) or spawns one entry (modo=1) in an external asteroid table.
// Optional macro ASTRO_WRAP_EN selects wrap-around instead of respawn in calc_pos.
module atualiza_asteroides
   import astro_pkg::*;
#(
   parameter int N        = 4,
   parameter int NUM_AST  = 8,
   parameter int STEP     = 1,
   localparam int AW      = (NUM_AST > 1) ? $clog2(NUM_AST) : 1,
   localparam int W       = word_width(N)
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          iniciar,
   input  logic          modo,
   input  logic [AW-1:0] spawn_idx,
   input  logic [N-1:0]  random_x,
   input  logic [N-1:0]  random_y,
   input  logic [1:0]    random_opcode,
   output logic [AW-1:0] mem_addr,
   input  logic [W-1:0]  mem_rdata,
   output logic          mem_we,
   output logic [W-1:0]  mem_wdata,
   output logic          ocupado,
   output logic          pronto
);

   localparam logic [AW-1:0] LAST = AW'(NUM_AST - 1);

   estado_t       estado;
   logic [AW-1:0] index;
   logic [W-1:0]  word_q;
   logic [W-1:0]  word_calc;
   logic          spawn_q;

   calc_pos #(.N(N), .STEP(STEP)) u_calc (
      .word_in      (mem_rdata),
      .random_x     (random_x),
      .random_y     (random_y),
      .random_opcode(random_opcode),
      .word_out     (word_calc)
   );

   assign mem_addr  = index;
   // A spawn writes the random inputs as they stand in ESCREVE itself.
   assign mem_wdata = (estado == ESCREVE && spawn_q) ?
                      {random_x, random_y, random_opcode} : word_q;

   always_ff @(posedge clock) begin
      if (reset) begin
         estado  <= IDLE;
         index   <= '0;
         word_q  <= '0;
         spawn_q <= 1'b0;
         mem_we  <= 1'b0;
         pronto  <= 1'b0;
         ocupado <= 1'b0;
      end else begin
         mem_we <= 1'b0;
         pronto <= 1'b0;
         case (estado)
            IDLE: begin
               if (iniciar) begin
                  ocupado <= 1'b1;
                  if (modo) begin
                     estado  <= ESCREVE;
                     index   <= spawn_idx;
                     spawn_q <= 1'b1;
                     mem_we  <= 1'b1;
                  end else begin
                     estado  <= LER;
                     index   <= '0;
                     spawn_q <= 1'b0;
                  end
               end
            end
            LER: estado <= CAPTURA;
            CAPTURA: begin
               word_q <= word_calc;
               estado <= ESCREVE;
               mem_we <= 1'b1;
            end
            ESCREVE: begin
               if (spawn_q || index == LAST) begin
                  estado <= FIM;
                  pronto <= 1'b1;
               end else begin
                  estado <= LER;
                  index  <= index + AW'(1);
               end
            end
            FIM: begin
               estado  <= IDLE;
               ocupado <= 1'b0;
            end
            default: begin
               estado  <= IDLE;
               ocupado <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_atualiza_asteroides.sv
// Self-checking bench for atualiza_asteroides (N=4, NUM_AST=4, STEP=1) with a
// memory model and a write/pronto scoreboard keyed on cycle, address and data.
module tb_atualiza_asteroides;

   logic       clock;
   logic       reset;
   logic       iniciar;
   logic       modo;
   logic [1:0] spawn_idx;
   logic [3:0] random_x;
   logic [3:0] random_y;
   logic [1:0] random_opcode;
   logic [1:0] mem_addr;
   logic [9:0] mem_rdata;
   logic       mem_we;
   logic [9:0] mem_wdata;
   logic       ocupado;
   logic       pronto;

   atualiza_asteroides #(.N(4), .NUM_AST(4), .STEP(1)) dut (
      .clock        (clock),
      .reset        (reset),
      .iniciar      (iniciar),
      .modo         (modo),
      .spawn_idx    (spawn_idx),
      .random_x     (random_x),
      .random_y     (random_y),
      .random_opcode(random_opcode),
      .mem_addr     (mem_addr),
      .mem_rdata    (mem_rdata),
      .mem_we       (mem_we),
      .mem_wdata    (mem_wdata),
      .ocupado      (ocupado),
      .pronto       (pronto)
   );

   // clock / reset
   initial clock = 1'b0;
   always #5 clock = ~clock;

   int cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   // memory model: registered read, write on mem_we, bulk preload
   logic [9:0] mem [4];
   logic [9:0] load_vals [4];
   logic       load_en = 1'b0;
   always @(posedge clock) begin
      if (load_en) begin
         for (int i = 0; i < 4; i++) mem[i] <= load_vals[i];
      end else if (mem_we) begin
         mem[mem_addr] <= mem_wdata;
      end
      mem_rdata <= mem[mem_addr];
   end

   // scoreboard: {cycle[31:0], addr[1:0], data[9:0]}
   logic [43:0] exp_q[$];
   int          pronto_q[$];
   int          checks = 0;
   int          errors = 0;
   int          n_writes = 0;
   int          n_pronto = 0;
   logic [43:0] exp_w;
   int          exp_p;

   always @(negedge clock) begin
      if (mem_we) begin
         n_writes++;
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_write: got addr=%0d data=%h cycle=%0d, expected no write",
                     mem_addr, mem_wdata, cyc);
         end else begin
            exp_w = exp_q.pop_front();
            if ({32'(cyc), mem_addr, mem_wdata} !== exp_w) begin
               errors++;
               $display("FAIL write: got addr=%0d data=%h cycle=%0d, expected addr=%0d data=%h cycle=%0d",
                        mem_addr, mem_wdata, cyc, exp_w[11:10], exp_w[9:0], exp_w[43:12]);
            end
         end
      end
      if (pronto) begin
         n_pronto++;
         checks++;
         if (pronto_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_pronto: got pronto at cycle=%0d, expected none", cyc);
         end else begin
            exp_p = pronto_q.pop_front();
            if (cyc !== exp_p) begin
               errors++;
               $display("FAIL pronto_cycle: got %0d, expected %0d", cyc, exp_p);
            end
         end
      end
   end

   // reference model of one entry update
   function automatic logic [9:0] model(input logic [9:0] w, input logic [3:0] rx,
                                        input logic [3:0] ry, input logic [1:0] rop);
      int x, y;
      logic [1:0] op;
      x  = int'(w[9:6]);
      y  = int'(w[5:2]);
      op = w[1:0];
      case (op)
         2'b00: y = y - 1;
         2'b01: y = y + 1;
         2'b10: x = x - 1;
         default: x = x + 1;
      endcase
`ifdef ASTRO_WRAP_EN
      return {x[3:0], y[3:0], op};
`else
      if (x < 0 || x > 15 || y < 0 || y > 15) return {rx, ry, rop};
      return {x[3:0], y[3:0], op};
`endif
   endfunction

   // driver tasks (entered and left at a negedge)
   task automatic load_mem(input logic [9:0] v0, input logic [9:0] v1,
                           input logic [9:0] v2, input logic [9:0] v3);
      load_vals[0] = v0; load_vals[1] = v1; load_vals[2] = v2; load_vals[3] = v3;
      load_en = 1'b1;
      @(negedge clock);
      load_en = 1'b0;
   endtask

   task automatic wait_done(input string name, input int limit);
      for (int i = 0; i < limit && (exp_q.size() != 0 || pronto_q.size() != 0); i++)
         @(negedge clock);
      repeat (4) @(negedge clock);
      checks++;
      if (exp_q.size() != 0 || pronto_q.size() != 0) begin
         errors++;
         $display("FAIL %s_timeout: got %0d writes/%0d pronto outstanding, expected 0",
                  name, exp_q.size(), pronto_q.size());
         exp_q.delete();
         pronto_q.delete();
      end
   endtask

   task automatic run_sweep(input string name, input bit do_load,
                            input logic [9:0] v0, input logic [9:0] v1,
                            input logic [9:0] v2, input logic [9:0] v3,
                            input logic [3:0] rx, input logic [3:0] ry,
                            input logic [1:0] rop, input bit extra_start);
      int d, w0, p0;
      logic [9:0] exp_m [4];
      if (do_load) load_mem(v0, v1, v2, v3);
      random_x = rx; random_y = ry; random_opcode = rop;
      for (int i = 0; i < 4; i++) exp_m[i] = model(mem[i], rx, ry, rop);
      w0 = n_writes; p0 = n_pronto; d = cyc;
      for (int i = 0; i < 4; i++) exp_q.push_back({32'(d + 3 + 3 * i), 2'(i), exp_m[i]});
      pronto_q.push_back(d + 13);
      iniciar = 1'b1; modo = 1'b0;
      @(negedge clock);
      iniciar = 1'b0;
      if (extra_start) begin
         repeat (3) @(negedge clock);
         iniciar = 1'b1; modo = 1'b1; spawn_idx = 2'd3;
         @(negedge clock);
         iniciar = 1'b0; modo = 1'b0;
      end
      wait_done(name, 60);
      checks++;
      if (n_writes - w0 !== 4 || n_pronto - p0 !== 1) begin
         errors++;
         $display("FAIL %s_counts: got %0d writes %0d pronto, expected 4 writes 1 pronto",
                  name, n_writes - w0, n_pronto - p0);
      end
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (mem[i] !== exp_m[i]) begin
            errors++;
            $display("FAIL %s_mem%0d: got %h, expected %h", name, i, mem[i], exp_m[i]);
         end
      end
   endtask

   // scenarios
   task automatic test_reset();
      reset = 1'b1; iniciar = 1'b0; modo = 1'b0; spawn_idx = 2'd0;
      random_x = 4'd0; random_y = 4'd0; random_opcode = 2'd0;
      repeat (3) @(negedge clock);
      checks++;
      if ({ocupado, pronto, mem_we, mem_addr, mem_wdata} !== 15'd0) begin
         errors++;
         $display("FAIL reset_state: got ocupado=%b pronto=%b we=%b addr=%0d wdata=%h, expected all 0",
                  ocupado, pronto, mem_we, mem_addr, mem_wdata);
      end
      reset = 1'b0;
      @(negedge clock);
      checks++;
      if (ocupado !== 1'b0) begin
         errors++;
         $display("FAIL idle_ocupado: got %b, expected 0", ocupado);
      end
   endtask

   task automatic test_boundary();
      logic [9:0] e1, e2;
`ifdef ASTRO_WRAP_EN
      e1 = 10'h013; e2 = 10'h23C;
`else
      e1 = 10'h0E5; e2 = 10'h0E5;
`endif
      run_sweep("boundary", 1'b1, 10'h15F, 10'h3D3, 10'h200, 10'h08A,
                4'd3, 4'd9, 2'b01, 1'b0);
      checks++;
      if (mem[0] !== 10'h19F || mem[1] !== e1 || mem[2] !== e2 || mem[3] !== 10'h04A) begin
         errors++;
         $display("FAIL boundary_words: got %h %h %h %h, expected 19f %h %h 04a",
                  mem[0], mem[1], mem[2], mem[3], e1, e2);
      end
   endtask

   task automatic test_random_sweeps();
      for (int t = 0; t < 3; t++)
         run_sweep("random", 1'b1, 10'($urandom_range(0, 1023)), 10'($urandom_range(0, 1023)),
                   10'($urandom_range(0, 1023)), 10'($urandom_range(0, 1023)),
                   4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                   2'($urandom_range(0, 3)), 1'b0);
   endtask

   task automatic test_spawn();
      int d, w0;
      load_mem(10'h111, 10'h222, 10'h333, 10'h044);
      random_x = 4'd3; random_y = 4'd9; random_opcode = 2'b01;
      w0 = n_writes; d = cyc;
      exp_q.push_back({32'(d + 1), 2'd2, 10'h0E5});
      pronto_q.push_back(d + 2);
      iniciar = 1'b1; modo = 1'b1; spawn_idx = 2'd2;
      @(negedge clock);
      iniciar = 1'b0; modo = 1'b0;
      wait_done("spawn", 20);
      checks++;
      if (n_writes - w0 !== 1 || mem[0] !== 10'h111 || mem[1] !== 10'h222 ||
          mem[2] !== 10'h0E5 || mem[3] !== 10'h044) begin
         errors++;
         $display("FAIL spawn_mem: got %0d writes, mem %h %h %h %h, expected 1 write, 111 222 0e5 044",
                  n_writes - w0, mem[0], mem[1], mem[2], mem[3]);
      end
   endtask

   task automatic test_reset_mid();
      int d, w0, p0;
      logic [9:0] e0;
      load_mem(10'h15F, 10'h0A5, 10'h14B, 10'h2B2);
      random_x = 4'd1; random_y = 4'd2; random_opcode = 2'b10;
      e0 = model(mem[0], 4'd1, 4'd2, 2'b10);
      w0 = n_writes; p0 = n_pronto; d = cyc;
      exp_q.push_back({32'(d + 3), 2'd0, e0});
      iniciar = 1'b1; modo = 1'b0;
      @(negedge clock);
      iniciar = 1'b0;
      repeat (4) @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      checks++;
      if (mem_we !== 1'b0 || ocupado !== 1'b0 || pronto !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid_outputs: got we=%b ocupado=%b pronto=%b, expected 0 0 0",
                  mem_we, ocupado, pronto);
      end
      reset = 1'b0;
      repeat (8) @(negedge clock);
      checks++;
      if (n_writes - w0 !== 1 || n_pronto - p0 !== 0 || mem[0] !== e0 || mem[1] !== 10'h0A5) begin
         errors++;
         $display("FAIL reset_mid_mem: got %0d writes %0d pronto mem0=%h mem1=%h, expected 1 0 %h 0a5",
                  n_writes - w0, n_pronto - p0, mem[0], mem[1], e0);
         exp_q.delete();
      end
      run_sweep("restart", 1'b0, 10'h0, 10'h0, 10'h0, 10'h0, 4'd7, 4'd7, 2'b11, 1'b0);
   endtask

   task automatic test_ignore_busy();
      run_sweep("ignore", 1'b1, 10'h2A6, 10'h1C5, 10'h0F8, 10'h39B,
                4'd5, 4'd6, 2'b00, 1'b1);
   endtask

   initial begin
      test_reset();
      test_boundary();
      test_spawn();
      test_random_sweeps();
      test_reset_mid();
      test_ignore_busy();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, expected completion");
      $fatal(1, "watchdog");
   end

endmodule
